secded_check_pipe: RTL
======================

SECDED_CHECK_PIPE -- requirements
Module: secded_check_pipe

Interface
REQ-001 SHALL expose parameter DW, default 32, meaning protected data width; legal values 32 and 64.
REQ-002 SHALL expose parameter CW, default 7, meaning check-bit width; CW=7 for DW=32 and CW=8 for DW=64, any other pairing rejected at elaboration.
REQ-003 SHALL expose parameter TW, default 32, meaning tag width (address or ID travelling with the word).
REQ-004 SHALL expose parameter CNTW, default 16, meaning error-counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports, clock and reset first:
 s_clk_i  in  1  clock
 s_rst_i  in  1  synchronous active-high reset
 s_valid_i  in  1  input word valid
 s_ready_o  out  1  block can accept input
 s_data_i  in  DW  raw data
 s_chk_i  in  CW  stored check bits
 s_tag_i  in  TW  tag
 s_valid_o  out  1  output word valid
 s_ready_i  in  1  downstream accepts output
 s_data_o  out  DW  corrected data
 s_chk_o  out  CW  check bits re-encoded from s_data_o
 s_tag_o  out  TW  tag delayed with word
 s_ce_o  out  1  correctable error on this word
 s_ue_o  out  1  uncorrectable error on this word
 s_cnt_clr_i  in  1  clear counters and capture
 s_ce_cnt_o  out  CNTW  correctable-error count
 s_ue_cnt_o  out  CNTW  uncorrectable-error count
 s_cap_vld_o  out  1  first-error capture valid
 s_cap_tag_o  out  TW  tag of first error
 s_cap_syn_o  out  CW  syndrome of first error

Function
REQ-007 Hsiao H-matrix: check bit k column = unit vector k; data column j = j-th CW-bit vector of weight 3 in ascending numeric order, continuing with weight-5 vectors in ascending order when weight-3 vectors are exhausted.
REQ-008 Syndrome = XOR of H columns selected by set data bits, XOR s_chk_i.
REQ-009 Classification: syndrome zero -> clean; odd weight equal to data column j -> CE, flip data bit j; odd weight 1 -> CE in check bits, data unchanged; any other nonzero -> UE, data passed unmodified.
REQ-010 Stage 1 SHALL register data, check bits, tag and computed syndrome; stage 2 SHALL register corrected data, re-encoded check bits, tag, CE and UE flags.
REQ-011 Latency SHALL be exactly 2 cycles from input handshake to s_valid_o with no backpressure; throughput one word per cycle.
REQ-012 A stage SHALL load when empty or when its contents move forward in the same cycle; s_ready_o = stage-1 empty or stage 1 advancing.
REQ-013 While s_valid_o=1 and s_ready_i=0 all s_*_o word outputs SHALL hold stable; s_ready_o drops once both stages are full.
REQ-014 s_ce_o and s_ue_o SHALL be mutually exclusive and qualified by s_valid_o.
REQ-015 Each counter SHALL increment by one on output handshake of a word carrying its flag, saturating at 2^CNTW-1.
REQ-016 First CE or UE at output handshake while s_cap_vld_o=0 SHALL load capture tag/syndrome and set s_cap_vld_o; later errors SHALL not overwrite.
REQ-017 s_cnt_clr_i SHALL zero both counters and s_cap_vld_o next cycle; clear wins over a same-cycle increment or capture (event dropped).
REQ-018 Pipeline data flow SHALL be unaffected by s_cnt_clr_i.

Reset
REQ-019 With s_rst_i=1 at a clock edge: both stages empty, s_valid_o=0, s_ready_o=1, counters 0, s_cap_vld_o=0, s_ce_o=s_ue_o=0, data/chk/tag/capture registers 0.
REQ-020 Reset mid-operation SHALL discard in-flight words without counting them.

Verification
REQ-021 DW=32, data 0xDEADBEEF with correct check bits, ready_i=1 -> s_data_o=0xDEADBEEF, ce=ue=0, 2 cycles later.
REQ-022 Same word with data bit 5 flipped -> s_data_o=0xDEADBEEF, s_ce_o=1, s_ce_cnt_o=1, capture tag/syndrome set.
REQ-023 Data bits 0 and 1 flipped -> s_ue_o=1, s_data_o equals corrupted input, s_ue_cnt_o=1; single check-bit flip -> ce=1, data unchanged, s_chk_o correct.
REQ-024 Stream 4 words, s_ready_i=0 for 3 cycles -> s_ready_o=0 after 2 accepted, outputs stable, no word lost or duplicated, order preserved.
REQ-025 CNTW=2, 5 CE words, then s_cnt_clr_i coincident with a 6th -> count 3 (saturated), then 0, s_cap_vld_o=0.
REQ-026 DW=64/CW=8 random single-bit flips across all 72 positions -> all corrected; random double flips -> all UE.

Source files
------------

// File: rtl/secded_check_pipe.sv
// Two-stage Hsiao SECDED check/correct pipeline with valid/ready flow control,
// saturating error counters and first-error capture.
module secded_check_pipe #(
    parameter int DW   = 32,
    parameter int CW   = 7,
    parameter int TW   = 32,
    parameter int CNTW = 16
) (
    input  logic            s_clk_i,
    input  logic            s_rst_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    input  logic [DW-1:0]   s_data_i,
    input  logic [CW-1:0]   s_chk_i,
    input  logic [TW-1:0]   s_tag_i,
    output logic            s_valid_o,
    input  logic            s_ready_i,
    output logic [DW-1:0]   s_data_o,
    output logic [CW-1:0]   s_chk_o,
    output logic [TW-1:0]   s_tag_o,
    output logic            s_ce_o,
    output logic            s_ue_o,
    input  logic            s_cnt_clr_i,
    output logic [CNTW-1:0] s_ce_cnt_o,
    output logic [CNTW-1:0] s_ue_cnt_o,
    output logic            s_cap_vld_o,
    output logic [TW-1:0]   s_cap_tag_o,
    output logic [CW-1:0]   s_cap_syn_o
);

    generate
        if (!((DW == 32 && CW == 7) || (DW == 64 && CW == 8))) begin : g_bad_cfg
            $error("secded_check_pipe: DW/CW must be 32/7 or 64/8");
        end
    endgenerate

    // Data columns: weight-3 codes ascending, then weight-5 codes once weight-3 runs out.
    function automatic logic [DW*CW-1:0] gen_h();
        logic [DW*CW-1:0] h;
        int n;
        h = '0;
        n = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 0; v < (1 << CW); v++) begin
                if ($countones(v) == w && n < DW) begin
                    h[n*CW +: CW] = CW'(v);
                    n++;
                end
            end
        end
        return h;
    endfunction

    localparam logic [DW*CW-1:0] H = gen_h();

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int j = 0; j < DW; j++) begin
            if (d[j]) c ^= H[j*CW +: CW];
        end
        return c;
    endfunction

    logic            s1_vld_q;
    logic [DW-1:0]   s1_data_q;
    logic [CW-1:0]   s1_chk_q;
    logic [TW-1:0]   s1_tag_q;
    logic [CW-1:0]   s1_syn_q;
    logic [CW-1:0]   s1_syn_d;

    logic            s2_vld_q;
    logic [DW-1:0]   s2_data_q;
    logic [CW-1:0]   s2_chk_q;
    logic [TW-1:0]   s2_tag_q;
    logic [CW-1:0]   s2_syn_q;
    logic            s2_ce_q;
    logic            s2_ue_q;
    logic [DW-1:0]   s2_data_d;
    logic [CW-1:0]   s2_chk_d;
    logic            s2_ce_d;
    logic            s2_ue_d;
    logic [DW-1:0]   flip;
    logic            syn_onehot;

    logic            s1_en;
    logic            s2_en;
    logic            out_hs;

    logic [CNTW-1:0] ce_cnt_q;
    logic [CNTW-1:0] ue_cnt_q;
    logic            cap_vld_q;
    logic [TW-1:0]   cap_tag_q;
    logic [CW-1:0]   cap_syn_q;

    // Each stage loads when empty or when its occupant leaves this cycle.
    assign s2_en     = ~s2_vld_q | s_ready_i;
    assign s1_en     = ~s1_vld_q | s2_en;
    assign s_ready_o = s1_en;
    assign out_hs    = s2_vld_q & s_ready_i;

    assign s1_syn_d  = encode(s_data_i) ^ s_chk_i;

    always_comb begin
        flip = '0;
        for (int j = 0; j < DW; j++) begin
            if (s1_syn_q == H[j*CW +: CW]) flip[j] = 1'b1;
        end
        syn_onehot = (s1_syn_q != '0) && ((s1_syn_q & (s1_syn_q - CW'(1))) == '0);
        s2_data_d  = s1_data_q ^ flip;
        s2_ce_d    = (|flip) | syn_onehot;
        s2_ue_d    = (s1_syn_q != '0) & ~s2_ce_d;
        s2_chk_d   = encode(s2_data_d);
    end

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_chk_q  <= '0;
            s1_tag_q  <= '0;
            s1_syn_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_chk_q  <= '0;
            s2_tag_q  <= '0;
            s2_syn_q  <= '0;
            s2_ce_q   <= 1'b0;
            s2_ue_q   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_vld_q  <= s_valid_i;
                s1_data_q <= s_data_i;
                s1_chk_q  <= s_chk_i;
                s1_tag_q  <= s_tag_i;
                s1_syn_q  <= s1_syn_d;
            end
            if (s2_en) begin
                s2_vld_q  <= s1_vld_q;
                s2_data_q <= s2_data_d;
                s2_chk_q  <= s2_chk_d;
                s2_tag_q  <= s1_tag_q;
                s2_syn_q  <= s1_syn_q;
                s2_ce_q   <= s2_ce_d;
                s2_ue_q   <= s2_ue_d;
            end
        end
    end

    // Clear takes priority; an error retiring in the same cycle is dropped.
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            ce_cnt_q  <= '0;
            ue_cnt_q  <= '0;
            cap_vld_q <= 1'b0;
            cap_tag_q <= '0;
            cap_syn_q <= '0;
        end else if (s_cnt_clr_i) begin
            ce_cnt_q  <= '0;
            ue_cnt_q  <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            if (out_hs && s2_ce_q && !(&ce_cnt_q)) ce_cnt_q <= ce_cnt_q + CNTW'(1);
            if (out_hs && s2_ue_q && !(&ue_cnt_q)) ue_cnt_q <= ue_cnt_q + CNTW'(1);
            if (out_hs && (s2_ce_q || s2_ue_q) && !cap_vld_q) begin
                cap_vld_q <= 1'b1;
                cap_tag_q <= s2_tag_q;
                cap_syn_q <= s2_syn_q;
            end
        end
    end

    assign s_valid_o   = s2_vld_q;
    assign s_data_o    = s2_data_q;
    assign s_chk_o     = s2_chk_q;
    assign s_tag_o     = s2_tag_q;
    assign s_ce_o      = s2_vld_q & s2_ce_q;
    assign s_ue_o      = s2_vld_q & s2_ue_q;
    assign s_ce_cnt_o  = ce_cnt_q;
    assign s_ue_cnt_o  = ue_cnt_q;
    assign s_cap_vld_o = cap_vld_q;
    assign s_cap_tag_o = cap_tag_q;
    assign s_cap_syn_o = cap_syn_q;

endmodule
